// File: rtl/telem_pkg.sv
// Shared types and defaults for the telemetry frame transmitter.
// Defining TELEM_TX_CHKSUM_EN adds the CSUM state to the frame FSM.
package telem_pkg;

    typedef logic [7:0] telem_byte_t;

    localparam int          NUM_COORDS_DEF = 4;
    localparam telem_byte_t SYNC_BYTE_DEF  = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SNAP = 3'd1,
        ST_SYNC = 3'd2,
        ST_SEQ  = 3'd3,
        ST_DATA = 3'd4
`ifdef TELEM_TX_CHKSUM_EN
        , ST_CSUM = 3'd5
`endif
    } tx_state_t;

endpackage

// File: rtl/telem_snap_buf.sv
// Snapshot register file: one slot per coordinate, one write port and one
// asynchronous read port. Contents are deliberately not reset.
module telem_snap_buf
    import telem_pkg::*;
#(
    parameter int NUM_COORDS = NUM_COORDS_DEF,
    parameter int AW         = 2
) (
    input  logic          clk,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_idx,
    input  logic [7:0]    i_wr_data,
    input  logic [AW-1:0] i_rd_idx,
    output logic [7:0]    o_rd_data
);

    logic [7:0] r_mem [NUM_COORDS];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_idx] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_idx];

endmodule

// File: rtl/telem_frame_tx.sv
// Telemetry frame transmitter: snapshots the coordinate bank, then sends
// SYNC, SEQ, D[0..N-1] (+ CSUM when TELEM_TX_CHKSUM_EN is defined) over valid/ready.
//
// state | meaning
// IDLE  | waiting for start
// SNAP  | walking coord_addr and capturing coord_data one cycle later
// SYNC  | presenting SYNC_BYTE
// SEQ   | presenting frame sequence number
// DATA  | presenting snapshot slot r_idx
// CSUM  | presenting XOR of SEQ and all data bytes (macro build only)
module telem_frame_tx
    import telem_pkg::*;
#(
    parameter int         NUM_COORDS = NUM_COORDS_DEF,
    parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [7:0] coord_addr,
    input  logic [7:0] coord_data,
    output logic       tx_valid,
    output logic [7:0] tx_byte,
    input  logic       tx_ready,
    output logic       busy,
    output logic       done
);

    localparam int         AW       = (NUM_COORDS > 1) ? $clog2(NUM_COORDS) : 1;
    localparam logic [7:0] LAST_IDX = 8'(NUM_COORDS - 1);

    tx_state_t  r_state;
    tx_state_t  w_state_nxt;
    logic [7:0] r_addr;
    logic [7:0] r_idx;
    logic [7:0] r_seq;
    logic       r_cap_en;
    logic       r_done;
    logic       w_xfer;
    logic       w_last_xfer;
    logic       w_snap_last;
    logic       w_buf_wr;
    logic [7:0] w_buf_rd;
`ifdef TELEM_TX_CHKSUM_EN
    logic [7:0] r_csum;
`endif

    // r_cap_en lags the address by one cycle, so r_idx is always the slot being written.
    assign w_buf_wr    = (r_state == ST_SNAP) && r_cap_en;
    assign w_snap_last = w_buf_wr && (r_idx == LAST_IDX);
    assign w_xfer      = tx_valid && tx_ready;

    telem_snap_buf #(
        .NUM_COORDS (NUM_COORDS),
        .AW         (AW)
    ) u_snap_buf (
        .clk        (clk),
        .i_wr_en    (w_buf_wr),
        .i_wr_idx   (r_idx[AW-1:0]),
        .i_wr_data  (coord_data),
        .i_rd_idx   (r_idx[AW-1:0]),
        .o_rd_data  (w_buf_rd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        tx_valid    = 1'b0;
        tx_byte     = 8'h00;
        w_last_xfer = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_nxt = ST_SNAP;
            end
            ST_SNAP: begin
                if (w_snap_last) w_state_nxt = ST_SYNC;
            end
            ST_SYNC: begin
                tx_valid = 1'b1;
                tx_byte  = SYNC_BYTE;
                if (tx_ready) w_state_nxt = ST_SEQ;
            end
            ST_SEQ: begin
                tx_valid = 1'b1;
                tx_byte  = r_seq;
                if (tx_ready) w_state_nxt = ST_DATA;
            end
            ST_DATA: begin
                tx_valid = 1'b1;
                tx_byte  = w_buf_rd;
                if (tx_ready && (r_idx == LAST_IDX)) begin
`ifdef TELEM_TX_CHKSUM_EN
                    w_state_nxt = ST_CSUM;
`else
                    w_state_nxt = ST_IDLE;
                    w_last_xfer = 1'b1;
`endif
                end
            end
`ifdef TELEM_TX_CHKSUM_EN
            ST_CSUM: begin
                tx_valid = 1'b1;
                tx_byte  = r_csum;
                if (tx_ready) begin
                    w_state_nxt = ST_IDLE;
                    w_last_xfer = 1'b1;
                end
            end
`endif
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr   <= 8'h00;
            r_idx    <= 8'h00;
            r_seq    <= 8'h00;
            r_cap_en <= 1'b0;
            r_done   <= 1'b0;
`ifdef TELEM_TX_CHKSUM_EN
            r_csum   <= 8'h00;
`endif
        end else begin
            r_done <= w_last_xfer;
            if (w_last_xfer) r_seq <= r_seq + 8'd1;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_addr   <= 8'h00;
                        r_idx    <= 8'h00;
                        r_cap_en <= 1'b0;
`ifdef TELEM_TX_CHKSUM_EN
                        r_csum   <= r_seq;
`endif
                    end
                end
                ST_SNAP: begin
                    r_cap_en <= 1'b1;
                    if (r_addr != LAST_IDX) r_addr <= r_addr + 8'd1;
                    if (r_cap_en) begin
                        r_idx <= w_snap_last ? 8'h00 : r_idx + 8'd1;
`ifdef TELEM_TX_CHKSUM_EN
                        r_csum <= r_csum ^ coord_data;
`endif
                    end
                end
                ST_DATA: begin
                    if (w_xfer) r_idx <= (r_idx == LAST_IDX) ? 8'h00 : r_idx + 8'd1;
                end
                default: ;
            endcase
        end
    end

    assign coord_addr = r_addr;
    assign busy       = (r_state != ST_IDLE);
    assign done       = r_done;

endmodule

// File: tb/tb_telem_frame_tx.sv
// Scoreboard bench for telem_frame_tx: stimulus pushes expected frame bytes,
// a negedge monitor pops and compares on every tx handshake.
module tb_telem_frame_tx;
    import telem_pkg::*;

    localparam int N = 4;

    logic       clk        = 1'b0;
    logic       rst        = 1'b1;
    logic       start      = 1'b0;
    logic       tx_ready   = 1'b1;
    logic [7:0] coord_data = 8'h00;
    logic [7:0] coord_addr;
    logic       tx_valid;
    logic [7:0] tx_byte;
    logic       busy;
    logic       done;

    logic [7:0] bank [N];
    logic [7:0] addr_q = 8'h00;
    logic [7:0] exp_q [$];
    logic       last_q [$];
    logic [7:0] exp_seq;
    bit         rdy_mode = 1'b0;
    logic [3:0] rdy_pat  = 4'b1001;
    int         rdy_ph   = 0;
    int         checks   = 0;
    int         errors   = 0;

    logic       pend_done  = 1'b0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_byte  = 8'h00;

    telem_frame_tx #(.NUM_COORDS(N), .SYNC_BYTE(8'hA5)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .coord_addr (coord_addr),
        .coord_data (coord_data),
        .tx_valid   (tx_valid),
        .tx_byte    (tx_byte),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Register bank model: read data appears the cycle after the address.
    always @(negedge clk) addr_q = coord_addr;
    always @(posedge clk) begin
        #1;
        coord_data = bank[addr_q[1:0]];
    end

    always @(posedge clk) begin
        #2;
        if (rdy_mode) begin
            tx_ready = rdy_pat[rdy_ph] ^ ($urandom_range(0, 4) == 0);
            rdy_ph   = (rdy_ph + 1) % 4;
        end else begin
            tx_ready = 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [7:0] e;
        logic       l;
        chk("done_pulse", done, pend_done);
        if (done) chk("busy_at_done", busy, 0);
        if (prev_stall) begin
            chk("stall_valid", tx_valid, 1);
            chk("stall_byte", tx_byte, prev_byte);
        end
        pend_done = 1'b0;
        if (tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_byte: got %0h expected no transfer at %0t", tx_byte, $time);
            end else begin
                e = exp_q.pop_front();
                l = last_q.pop_front();
                chk("tx_byte", tx_byte, e);
                pend_done = l;
            end
        end
        prev_stall = tx_valid && !tx_ready && !rst;
        prev_byte  = tx_byte;
    end

    task automatic push_b(input logic [7:0] b, input logic last);
        exp_q.push_back(b);
        last_q.push_back(last);
    endtask

    task automatic push_frame(input logic [7:0] seq);
`ifdef TELEM_TX_CHKSUM_EN
        logic [7:0] cs;
        cs = seq;
        for (int k = 0; k < N; k++) cs = cs ^ bank[k];
`endif
        push_b(8'hA5, 1'b0);
        push_b(seq, 1'b0);
        for (int k = 0; k < N; k++) begin
`ifdef TELEM_TX_CHKSUM_EN
            push_b(bank[k], 1'b0);
`else
            push_b(bank[k], k == N - 1);
`endif
        end
`ifdef TELEM_TX_CHKSUM_EN
        push_b(cs, 1'b1);
`endif
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 300);
        chk(name, done, 1);
    endtask

    task automatic wait_byte(input string name, input logic [7:0] b);
        int n;
        n = 0;
        while (!(tx_valid && tx_byte == b) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(name, tx_valid && (tx_byte == b), 1);
    endtask

    task automatic set_bank(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] d);
        bank[0] = a; bank[1] = b; bank[2] = c; bank[3] = d;
    endtask

    initial begin
        int cnt;
        logic busy_seen;
        set_bank(8'h11, 8'h22, 8'h33, 8'h44);

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_byte", tx_byte, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_coord_addr", coord_addr, 0);
        rst = 1'b0;
        exp_seq = 8'h00;

        // Frame 1: hand-computed bytes, no backpressure, latency check
        push_b(8'hA5, 0); push_b(8'h00, 0);
        push_b(8'h11, 0); push_b(8'h22, 0); push_b(8'h33, 0);
`ifdef TELEM_TX_CHKSUM_EN
        push_b(8'h44, 0); push_b(8'h44, 1);
`else
        push_b(8'h44, 1);
`endif
        pulse_start();
        chk("snap_addr0", coord_addr, 0);
        chk("snap_busy", busy, 1);
        cnt = 1;
        while (!tx_valid && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        chk("first_valid_cycle", cnt, N + 2);
        wait_done("done_f1");
        exp_seq++;

        // Frame 2: pseudo-random backpressure
        rdy_mode = 1'b1;
        push_frame(exp_seq);
        pulse_start();
        wait_done("done_f2");
        rdy_mode = 1'b0;
        exp_seq++;

        // Frame 3: live data changes after snapshot must not leak in
        push_frame(exp_seq);
        pulse_start();
        wait_byte("snap_end_f3", 8'hA5);
        set_bank(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        wait_done("done_f3");
        set_bank(8'h11, 8'h22, 8'h33, 8'h44);
        exp_seq++;

        // Frame 4: start during DATA is ignored
        push_frame(exp_seq);
        pulse_start();
        wait_byte("in_data_f4", 8'h11);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("done_f4");
        exp_seq++;
        busy_seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            busy_seen = busy_seen | busy;
        end
        chk("start_ignored", busy_seen, 0);

        // 256 frames: SEQ wraps FF->00
        for (int f = 0; f < 256; f++) begin
            set_bank(8'(f * 7), 8'(f * 13 + 1), 8'(f ^ 8'h5A), 8'(255 - f));
            push_frame(exp_seq);
            pulse_start();
            wait_done("done_loop");
            exp_seq++;
        end
        set_bank(8'h11, 8'h22, 8'h33, 8'h44);

        // Abort with rst while DATA index 2 is presented
        push_frame(exp_seq);
        pulse_start();
        wait_byte("in_data2", 8'h33);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_tx_valid", tx_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        rst = 1'b0;
        exp_q.delete();
        last_q.delete();
        exp_seq = 8'h00;
        push_frame(exp_seq);
        pulse_start();
        wait_done("done_after_abort");

        // start held high: back-to-back frames 00,01,02
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_seq = 8'h00;
        for (int f = 0; f < 3; f++) push_frame(8'(f));
        start = 1'b1;
        for (int f = 0; f < 3; f++) begin
            wait_done("done_b2b");
            if (f < 2) begin
                @(negedge clk);
                chk("b2b_snap_busy", busy, 1);
                chk("b2b_snap_addr", coord_addr, 0);
                if (f == 1) start = 1'b0;
            end
        end
        repeat (3) @(negedge clk);
        chk("b2b_stopped", busy, 0);
        chk("queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/telem_frame_tx.md
# telem_frame_tx

Telemetry frame transmitter. On a start pulse it snapshots the coordinate/time register bank (X, Y, Z, T, 8 bits each) through an 8-bit register select. It then emits one framed byte stream over a valid/ready interface to the downlink serializer. It sits on the read side of the telemetry register bank, opposite the load/decode path that writes it.

## Interface
Parameters:
- NUM_COORDS, 4, number of 8-bit registers read per frame (legal 1..255); addresses 0..NUM_COORDS-1
- SYNC_BYTE, 8'hA5, first byte of every frame

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; one clock, reset is synchronous and active-high
- start  in  1  frame request; sampled only in IDLE
- coord_addr  out  8  register-bank select during snapshot
- coord_data  in  8  register-bank read data; valid the cycle after coord_addr
- tx_valid  out  1  tx_byte holds a frame byte
- tx_byte  out  8  frame byte
- tx_ready  in  1  downstream accepts byte when tx_valid && tx_ready
- busy  out  1  high from start acceptance through last byte transfer
- done  out  1  one-cycle pulse after the last byte transfers

## Operation
- Frame format: SYNC_BYTE, SEQ, D[0]..D[NUM_COORDS-1], then optional CSUM (see Configuration).
- SEQ: 8-bit frame counter. Reset value 0. Increments once per completed frame, 8'hFF wraps to 8'h00. Aborted frames do not increment it.
- States: IDLE, SNAP, SYNC, SEQ, DATA, CSUM (macro only).
- IDLE: if start=1, go to SNAP and assert busy. Otherwise stay in IDLE.
- SNAP: drive coord_addr = 0,1,..,NUM_COORDS-1 on consecutive cycles. Capture coord_data into snapshot slot k one cycle after address k. After the last capture, go to SYNC.
- SYNC / SEQ / DATA / CSUM: present the byte with tx_valid=1. Advance only on tx_valid && tx_ready.
- DATA: index runs 0..NUM_COORDS-1 from the snapshot, never from live coord_data.
- Last byte transfer: go to IDLE, pulse done, increment SEQ, deassert busy.
- start while not in IDLE is ignored. No queuing.
- coord_addr holds its last value outside SNAP. Reset value 0.
- Reset values: tx_valid 0, tx_byte 0, busy 0, done 0, coord_addr 0, SEQ 0, state IDLE. Snapshot contents don't-care.
- rst mid-frame: abort on the next edge, with all of the above reset values. No done pulse. A partial frame is acceptable to downstream.

## Timing
- start at edge 0 → coord_addr=0 in cycle 1. Snapshot completes at edge NUM_COORDS+1. tx_valid rises in cycle NUM_COORDS+2 with SYNC_BYTE.
- With tx_ready held high, one byte transfers per cycle with no bubbles.
- While tx_valid && !tx_ready, tx_byte and tx_valid are held stable.
- tx_valid never drops without a transfer, except on rst.
- done is high in the cycle after the final transfer, coincident with busy=0.
- A start in that same cycle is accepted, giving back-to-back frames.
- Minimum frame period with no backpressure: NUM_COORDS + 1 snapshot cycles + bytes + 1.

## Configuration
- TELEM_TX_CHKSUM_EN defined: append CSUM = XOR of SEQ and all D[k]; SYNC_BYTE is excluded. Frame length is NUM_COORDS+3.
- Not defined: no CSUM state or logic; the frame ends after D[NUM_COORDS-1]. Frame length is NUM_COORDS+2.

## Structure
- Shared package telem_pkg holds:
  - state enum
  - SYNC_BYTE default constant
  - 8-bit telemetry byte typedef
  - default NUM_COORDS constant (4)
- One sub-module, telem_snap_buf: NUM_COORDS×8 register file with one write port (slot k, data) and one read port. The top level holds the FSM, SEQ counter and checksum.

## Test plan
- Coords 11,22,33,44; SEQ=0; tx_ready=1; start → bytes A5 00 11 22 33 44 44 with macro, or A5 00 11 22 33 44 without. done one cycle after the last byte.
- Same coords, tx_ready toggled 1-0-0-1 pseudo-randomly → identical byte sequence; tx_byte stable on every stalled cycle.
- Change coord_data to 8'hFF after SNAP ends → frame still carries 11 22 33 44.
- start pulsed during DATA → ignored; SEQ advances by 1 only. Then 256 frames → SEQ byte wraps FF→00.
- rst asserted while DATA index=2 → next cycle tx_valid=0, busy=0, no done. The next frame carries SEQ=00.
- start held high continuously → back-to-back frames with SEQ 00,01,02. Each frame's SNAP begins the cycle after its done.
